// File: rtl/nabp_angle_sequencer_if.sv
// Host-to-swap-controller angle handshake bundle; NABP_ANGLE_SEQ_ABORT_EN adds the abort input.
// slave = sequencer side, master = host/controller side.
interface nabp_angle_sequencer_if #(
    parameter int ANGLE_W = 9
);
    logic               start;
    logic               src_ready;
    logic               sc_next_angle;
    logic               sc_pr_done;
`ifdef NABP_ANGLE_SEQ_ABORT_EN
    logic               abort;
`endif
    logic [ANGLE_W-1:0] sc_angle;
    logic               sc_has_next_angle;
    logic               sc_next_angle_ack;
    logic [ANGLE_W-1:0] issued_count;
    logic               busy;
    logic               done;

    modport slave (
        input  start, src_ready, sc_next_angle, sc_pr_done,
`ifdef NABP_ANGLE_SEQ_ABORT_EN
        input  abort,
`endif
        output sc_angle, sc_has_next_angle, sc_next_angle_ack, issued_count, busy, done
    );

    modport master (
        output start, src_ready, sc_next_angle, sc_pr_done,
`ifdef NABP_ANGLE_SEQ_ABORT_EN
        output abort,
`endif
        input  sc_angle, sc_has_next_angle, sc_next_angle_ack, issued_count, busy, done
    );
endinterface

// File: rtl/nabp_angle_sequencer.sv
// Sequences projection angles into the filtered-RAM swap controller for one frame; all outputs registered.
// Optional early abort of PRIME/RUN is enabled by defining NABP_ANGLE_SEQ_ABORT_EN.
module nabp_angle_sequencer #(
    parameter int ANGLE_W    = 9,
    parameter int NUM_ANGLES = 180,
    parameter int ANGLE_STEP = 1,
    parameter int ANGLE_MOD  = 180
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nabp_angle_sequencer_if.slave  bus
);
    localparam int AW1 = ANGLE_W + 1;
    localparam logic [ANGLE_W:0]   STEP_W = AW1'(ANGLE_STEP);
    localparam logic [ANGLE_W:0]   MOD_W  = AW1'(ANGLE_MOD);
    localparam logic [ANGLE_W-1:0] NUM_W  = ANGLE_W'(NUM_ANGLES);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [ANGLE_W-1:0] issued_count_q, issued_count_d;
    logic               has_next_q, has_next_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               abort_w;
    logic [ANGLE_W:0]   angle_sum;
    logic [ANGLE_W-1:0] angle_next;
    logic [ANGLE_W-1:0] count_inc;

`ifdef NABP_ANGLE_SEQ_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    // One extra bit so angle + step cannot overflow before the modulus wrap.
    assign angle_sum  = {1'b0, angle_q} + STEP_W;
    assign angle_next = (angle_sum >= MOD_W) ? ANGLE_W'(angle_sum - MOD_W) : ANGLE_W'(angle_sum);
    assign count_inc  = issued_count_q + ANGLE_W'(1);

    always_comb begin
        state_d        = state_q;
        angle_d        = angle_q;
        issued_count_d = issued_count_q;
        has_next_d     = has_next_q;
        ack_d          = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    angle_d        = '0;
                    issued_count_d = '0;
                    has_next_d     = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = S_PRIME;
                end
            end
            S_PRIME: begin
                if (abort_w) begin
                    has_next_d = 1'b0;
                    state_d    = S_DRAIN;
                end else if (bus.src_ready) begin
                    // Unsolicited first ack: the controller's ready state only rotates on ack.
                    ack_d   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_w) begin
                    has_next_d = 1'b0;
                    state_d    = S_DRAIN;
                end else if (ack_q) begin
                    // A request still held during the ack cycle is the one just answered.
                    issued_count_d = count_inc;
                    angle_d        = angle_next;
                    has_next_d     = (count_inc < NUM_W);
                    if (count_inc >= NUM_W) state_d = S_DRAIN;
                end else if (bus.sc_next_angle && bus.src_ready && has_next_q) begin
                    ack_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus.sc_pr_done) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                angle_d        = '0;
                issued_count_d = '0;
                has_next_d     = 1'b0;
                busy_d         = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            angle_q        <= '0;
            issued_count_q <= '0;
            has_next_q     <= 1'b0;
            ack_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            angle_q        <= angle_d;
            issued_count_q <= issued_count_d;
            has_next_q     <= has_next_d;
            ack_q          <= ack_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.sc_angle          = angle_q;
    assign bus.sc_has_next_angle = has_next_q;
    assign bus.sc_next_angle_ack = ack_q;
    assign bus.issued_count      = issued_count_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Directed bench for nabp_angle_sequencer: 4 angles, step 50, modulus 180.
module tb_nabp_angle_sequencer;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nabp_angle_sequencer_if #(.ANGLE_W(AW)) bus();

    nabp_angle_sequencer #(
        .ANGLE_W(AW), .NUM_ANGLES(4), .ANGLE_STEP(50), .ANGLE_MOD(180)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          start, sr, req, prd;
        int            n;
        logic [21:0]   exp;
        string         name;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [21:0] ex(input logic ack, input int ang, input logic hn,
                                       input int cnt, input logic busy, input logic done);
        return {ack, AW'(ang), hn, AW'(cnt), busy, done};
    endfunction

    function automatic vec_t mk(input logic st, input logic sr, input logic rq, input logic pd,
                                input int n, input logic [21:0] e, input string nm);
        vec_t v;
        v.start = st; v.sr = sr; v.req = rq; v.prd = pd; v.n = n; v.exp = e; v.name = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [21:0] e);
        logic [21:0] a;
        a = {bus.sc_next_angle_ack, bus.sc_angle, bus.sc_has_next_angle,
             bus.issued_count, bus.busy, bus.done};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got ack=%0b ang=%0d has_next=%0b cnt=%0d busy=%0b done=%0b, want ack=%0b ang=%0d has_next=%0b cnt=%0d busy=%0b done=%0b",
                     nm, a[21], a[20:12], a[11], a[10:2], a[1], a[0],
                     e[21], e[20:12], e[11], e[10:2], e[1], e[0]);
        end
    endtask

    task automatic step(input logic rn, input logic st, input logic sr, input logic rq,
                        input logic pd, input logic ab, input logic [21:0] e, input string nm);
        @(negedge clk);
        reset_n           = rn;
        bus.start         = st;
        bus.src_ready     = sr;
        bus.sc_next_angle = rq;
        bus.sc_pr_done    = pd;
`ifdef NABP_ANGLE_SEQ_ABORT_EN
        bus.abort         = ab;
`else
        if (ab) $display("abort requested but feature not built");
`endif
        @(posedge clk);
        #1;
        check(nm, e);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0; bus.src_ready = 1'b0; bus.sc_next_angle = 1'b0; bus.sc_pr_done = 1'b0;
`ifdef NABP_ANGLE_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        //                st  sr  rq  pd  n        ack ang hn cnt busy done
        tbl[0]  = mk(1, 1, 0, 0, 1,  ex(0,   0, 1, 0, 1, 0), "prime_entry");
        tbl[1]  = mk(0, 1, 0, 0, 1,  ex(1,   0, 1, 0, 1, 0), "prime_ack");
        tbl[2]  = mk(0, 1, 0, 0, 1,  ex(0,  50, 1, 1, 1, 0), "count1");
        tbl[3]  = mk(0, 0, 1, 0, 10, ex(0,  50, 1, 1, 1, 0), "src_stall");
        tbl[4]  = mk(0, 1, 1, 0, 1,  ex(1,  50, 1, 1, 1, 0), "ack_ang50");
        tbl[5]  = mk(0, 1, 1, 0, 1,  ex(0, 100, 1, 2, 1, 0), "no_b2b_1");
        tbl[6]  = mk(0, 1, 1, 0, 1,  ex(1, 100, 1, 2, 1, 0), "ack_ang100");
        tbl[7]  = mk(0, 1, 1, 0, 1,  ex(0, 150, 1, 3, 1, 0), "no_b2b_2");
        tbl[8]  = mk(0, 1, 1, 0, 1,  ex(1, 150, 1, 3, 1, 0), "ack_ang150");
        tbl[9]  = mk(0, 1, 1, 0, 1,  ex(0,  20, 0, 4, 1, 0), "last_wrap");
        tbl[10] = mk(1, 1, 1, 0, 1,  ex(0,  20, 0, 4, 1, 0), "start_in_drain");
        tbl[11] = mk(0, 1, 0, 0, 5,  ex(0,  20, 0, 4, 1, 0), "drain_wait");
        tbl[12] = mk(0, 0, 0, 1, 1,  ex(0,  20, 0, 4, 1, 1), "done_pulse");
        tbl[13] = mk(1, 0, 0, 0, 1,  ex(0,   0, 0, 0, 0, 0), "idle_after_done");
        tbl[14] = mk(0, 0, 0, 0, 1,  ex(0,   0, 0, 0, 0, 0), "start_in_done_ignored");

        step(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0), "reset");
        step(0, 1, 1, 1, 1, 0, ex(0, 0, 0, 0, 0, 0), "reset_hold");

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++)
                step(1, tbl[i].start, tbl[i].sr, tbl[i].req, tbl[i].prd, 0, tbl[i].exp, tbl[i].name);
        end

        // PRIME holds off its ack while the source is not ready, then reset lands mid-RUN.
        step(1, 1, 0, 0, 0, 0, ex(0,   0, 1, 0, 1, 0), "r_prime");
        for (int c = 0; c < 3; c++)
            step(1, 0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1, 0), "r_prime_stall");
        step(1, 0, 1, 0, 0, 0, ex(1,   0, 1, 0, 1, 0), "r_prime_ack");
        step(1, 0, 1, 1, 0, 0, ex(0,  50, 1, 1, 1, 0), "r_held_same_req");
        step(1, 0, 1, 1, 0, 0, ex(1,  50, 1, 1, 1, 0), "r_ack2");
        step(1, 0, 1, 0, 0, 0, ex(0, 100, 1, 2, 1, 0), "r_count2");
        step(0, 0, 1, 1, 0, 0, ex(0,   0, 0, 0, 0, 0), "r_reset_mid_run");
        step(1, 0, 1, 1, 0, 0, ex(0,   0, 0, 0, 0, 0), "r_idle_no_ack");

`ifdef NABP_ANGLE_SEQ_ABORT_EN
        step(1, 1, 1, 0, 0, 0, ex(0,   0, 1, 0, 1, 0), "a_prime");
        step(1, 0, 1, 0, 0, 0, ex(1,   0, 1, 0, 1, 0), "a_ack0");
        step(1, 0, 1, 0, 0, 0, ex(0,  50, 1, 1, 1, 0), "a_cnt1");
        step(1, 0, 1, 1, 0, 0, ex(1,  50, 1, 1, 1, 0), "a_ack1");
        step(1, 0, 1, 0, 0, 0, ex(0, 100, 1, 2, 1, 0), "a_cnt2");
        step(1, 0, 1, 1, 0, 0, ex(1, 100, 1, 2, 1, 0), "a_ack2");
        step(1, 0, 1, 0, 0, 0, ex(0, 150, 1, 3, 1, 0), "a_cnt3");
        step(1, 0, 1, 1, 0, 1, ex(0, 150, 0, 3, 1, 0), "a_abort_beats_ack");
        step(1, 0, 1, 1, 0, 0, ex(0, 150, 0, 3, 1, 0), "a_drain");
        step(1, 0, 0, 0, 1, 0, ex(0, 150, 0, 3, 1, 1), "a_done");
        step(1, 0, 0, 0, 0, 0, ex(0,   0, 0, 0, 0, 0), "a_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
